// File: rtl/mem_bist.sv
// Single-port RAM with a fill/verify self-test sequencer and a byte-select LED view.
// The manual port owns the RAM whenever the sequencer is idle or done.
module mem_bist #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Op,
    input  logic [1:0]        Mode,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Write_Reg,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [1:0]        Select,
    output logic [DATA_W-1:0] R_Data,
    output logic [7:0]        LED,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-1:0] ErrAddr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_VERIFY, S_DONE} state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cmp_addr;
    logic                cmp_vld;
    logic [DATA_W-1:0]   seq_word;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                busy;
    logic                mismatch;
    logic [ADDR_W-1:0]   ram_addr;
    int                  sel_idx;

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        case (m)
            2'b00:   pat = '0;
            2'b01:   pat = '1;
            2'b10:   pat = a[0] ? {NB{8'hAA}} : {NB{8'h55}};
            default: pat = DATA_W'(a);
        endcase
    endfunction

    assign busy     = (state == S_FILL) || (state == S_VERIFY);
    assign Busy     = busy;
    assign Done     = (state == S_DONE);
    assign ram_addr = busy ? cnt : Addr;
    assign mismatch = seq_word != pat(mode_q, cmp_addr);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= S_IDLE;
            mode_q   <= 2'b00;
            cnt      <= '0;
            cmp_addr <= '0;
            cmp_vld  <= 1'b0;
            Error    <= 1'b0;
            ErrAddr  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        mode_q  <= Mode;
                        Error   <= 1'b0;
                        ErrAddr <= '0;
                        cnt     <= '0;
                        cmp_vld <= 1'b0;
                        state   <= Op ? S_VERIFY : S_FILL;
                    end
                end
                S_FILL: begin
                    // counter wraps to 0 on the last write, ready for VERIFY
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= S_VERIFY;
                end
                S_VERIFY: begin
                    cnt      <= cnt + 1'b1;
                    cmp_addr <= cnt;
                    cmp_vld  <= 1'b1;
                    if (cmp_vld && mismatch) begin
                        state   <= S_DONE;
                        Error   <= 1'b1;
                        ErrAddr <= cmp_addr;
                        cmp_vld <= 1'b0;
                    end else if (cmp_vld && (&cmp_addr)) begin
                        state   <= S_DONE;
                        cmp_vld <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; one shared address for both the write and read paths.
    always_ff @(posedge Clk) begin
        if (state == S_FILL)
            mem[ram_addr] <= pat(mode_q, cnt);
        else if (!busy && Write_Reg)
            mem[ram_addr] <= W_Data;
        if (state == S_VERIFY)
            seq_word <= mem[ram_addr];
    end

    // Manual read is read-first and freezes while the sequencer owns the RAM.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            R_Data <= '0;
        else if (!busy)
            R_Data <= mem[ram_addr];
    end

    always_comb begin
        sel_idx = int'(Select) % NB;
        LED     = R_Data[sel_idx*8 +: 8];
    end

endmodule

// File: tb/tb_mem_bist.sv
// Randomized self-check of mem_bist against a plain array model of the RAM and
// the command latency rules.
module tb_mem_bist;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int D  = 64;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Start = 1'b0;
    logic          Op = 1'b0;
    logic [1:0]    Mode = 2'b00;
    logic [AW-1:0] Addr = '0;
    logic          Write_Reg = 1'b0;
    logic [DW-1:0] W_Data = '0;
    logic [1:0]    Select = 2'b00;
    logic [DW-1:0] R_Data;
    logic [7:0]    LED;
    logic          Busy, Done, Error;
    logic [AW-1:0] ErrAddr;

    mem_bist #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Mode(Mode), .Addr(Addr),
        .Write_Reg(Write_Reg), .W_Data(W_Data), .Select(Select), .R_Data(R_Data),
        .LED(LED), .Busy(Busy), .Done(Done), .Error(Error), .ErrAddr(ErrAddr)
    );

    always #5 Clk = ~Clk;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] ref_mem [D];
    bit            known [D];
    logic [1:0]    last_mode = 2'b00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_pat(input logic [1:0] m, input int a);
        case (m)
            2'd0: return 32'h0000_0000;
            2'd1: return 32'hFFFF_FFFF;
            2'd2: return (a % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
            default: return 32'(a);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  64'(Busy), 0);
        check({tag, "_done"},  64'(Done), 0);
        check({tag, "_err"},   64'(Error), 0);
        check({tag, "_eaddr"}, 64'(ErrAddr), 0);
        check({tag, "_rdata"}, 64'(R_Data), 0);
        check({tag, "_led"},   64'(LED), 0);
    endtask

    task automatic man_write(input int a, input logic [DW-1:0] d);
        Addr = AW'(a); W_Data = d; Write_Reg = 1'b1;
        tick();
        Write_Reg = 1'b0;
        if (known[a]) check("wr_old", 64'(R_Data), 64'(ref_mem[a]));
        ref_mem[a] = d;
        known[a] = 1'b1;
    endtask

    task automatic man_read(input int a, input int sel);
        logic [DW-1:0] w;
        Addr = AW'(a); Select = 2'(sel);
        tick();
        if (known[a]) begin
            w = ref_mem[a];
            check("rd_data", 64'(R_Data), 64'(w));
            check("rd_led", 64'(LED), 64'((w >> (8 * (sel % 4))) & 32'hFF));
        end
    endtask

    task automatic run_cmd(input bit op, input logic [1:0] mode, input bit lockout);
        logic [DW-1:0] r0;
        int lat, bc, exp_lat, exp_ea;
        bit exp_err;
        exp_err = 1'b0; exp_ea = 0;
        exp_lat = op ? D + 1 : 2 * D + 1;
        if (op) begin
            for (int a = 0; a < D; a++)
                if (ref_mem[a] != ref_pat(mode, a)) begin
                    exp_err = 1'b1; exp_ea = a; exp_lat = a + 2;
                    break;
                end
        end
        Addr = AW'($urandom_range(D - 1)); Write_Reg = 1'b0;
        Start = 1'b1; Op = op; Mode = mode;
        tick();
        Start = 1'b0; Op = 1'($urandom); Mode = 2'($urandom);
        r0 = R_Data;
        if (known[Addr]) check("e0_rdata", 64'(R_Data), 64'(ref_mem[Addr]));
        check("e0_busy", 64'(Busy), 1);
        lat = 0; bc = 0;
        while (!Done && lat < 400) begin
            if (Busy) bc++;
            if (lockout && lat == 20) begin
                Write_Reg = 1'b1; Addr = AW'(10); W_Data = '0; Start = 1'b1;
            end
            if (lockout && lat == 21) begin
                Write_Reg = 1'b0; Start = 1'b0;
            end
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(bc), 64'(exp_lat));
        check("busy_end", 64'(Busy), 0);
        check("error", 64'(Error), 64'(exp_err));
        check("erraddr", 64'(ErrAddr), 64'(exp_ea));
        check("rdata_hold", 64'(R_Data), 64'(r0));
        if (!op) begin
            for (int a = 0; a < D; a++) begin
                ref_mem[a] = ref_pat(mode, a);
                known[a] = 1'b1;
            end
        end
        last_mode = mode;
    endtask

    initial begin
        for (int a = 0; a < D; a++) known[a] = 1'b0;
        #1;
        check_reset_outputs("por");
        #12 Rst = 1'b0;
        tick();

        // every pattern, with spot reads of the addresses the plan calls out
        run_cmd(1'b0, 2'b00, 1'b0);
        man_read(5, 0);
        run_cmd(1'b0, 2'b01, 1'b0);
        man_read(40, 2);
        run_cmd(1'b0, 2'b11, 1'b0);
        man_read(17, 0);
        check("addr17_led", 64'(LED), 64'h11);
        run_cmd(1'b0, 2'b10, 1'b0);
        man_read(1, 3);
        check("addr1_led", 64'(LED), 64'hAA);

        // planted fault, mid-clock reset, then repair
        man_write(3, '0);
        run_cmd(1'b1, 2'b10, 1'b0);
        man_read(17, 1);
        #3 Rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        #3 Rst = 1'b0;
        man_read(3, 0);
        man_write(3, ref_pat(2'b10, 3));
        run_cmd(1'b1, 2'b10, 1'b0);

        run_cmd(1'b0, 2'b11, 1'b1);
        man_read(10, 0);

        // abort in FILL
        Start = 1'b1; Op = 1'b0; Mode = 2'b01;
        tick();
        Start = 1'b0;
        repeat (20) tick();
        #2 Rst = 1'b1;
        #1 check_reset_outputs("fill_rst");
        #3 Rst = 1'b0;
        for (int a = 0; a < D; a++) known[a] = 1'b0;
        tick();
        run_cmd(1'b0, 2'($urandom), 1'b0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(3))
                0: man_write($urandom_range(D - 1), $urandom);
                1: man_read($urandom_range(D - 1), $urandom_range(3));
                2: run_cmd(1'b0, 2'($urandom), 1'b0);
                default: run_cmd(1'b1, $urandom_range(1) ? last_mode : 2'($urandom), 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
